// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 width codes,
// FSM state encoding and store byte-lane masks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic {
    IDLE      = 1'b0,
    READ_WAIT = 1'b1
  } lsu_state_e;

  function automatic logic f3_legal_load(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f3_legal_store(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed data-memory bus: the LSU is master, the memory is slave.
// mem_data_out is valid the cycle after a read request.
interface load_store_unit_if #(
  parameter int MEM_AW = 8
);
  logic              mem_request;
  logic              mem_we_re;
  logic [MEM_AW-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic [3:0]        mem_mask;
  logic [31:0]       mem_data_out;

  modport master (
    output mem_request, mem_we_re, mem_address, mem_data_in, mem_mask,
    input  mem_data_out
  );

  modport slave (
    input  mem_request, mem_we_re, mem_address, mem_data_in, mem_mask,
    output mem_data_out
  );
endinterface

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a memory word and sign- or
// zero-extends it according to funct3. Purely combinational.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word_i >> {off_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns byte-addressed RV32I accesses into masked
// word requests, waits one cycle for read data and returns aligned loads.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               is_load_i,
  input  logic               is_store_i,
  input  logic [2:0]         funct3_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        store_data_i,
  input  logic [4:0]         rd_in_i,
  output logic               load_valid_o,
  output logic [31:0]        load_data_o,
  output logic [4:0]         load_rd_o,
  output logic               misalign_err_o,
  load_store_unit_if.master  mem
);

  lsu_state_e  state_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        load_valid_q;
  logic [31:0] load_data_q;
  logic [4:0]  load_rd_q;
  logic        misalign_q;

  logic [1:0]  off;
  logic        access;
  logic        err;
  logic        issue;
  logic        is_half;
  logic        is_word;
  logic        f3_legal;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] aligned;

  // Upper address bits alias onto the same word; they are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:MEM_AW+2];

  assign off         = addr_i[1:0];
  assign req_ready_o = (state_q == IDLE);
  assign access      = req_ready_o && req_valid_i && (is_load_i || is_store_i);

  always_comb begin
    is_half  = (funct3_i == F3_H) || (funct3_i == F3_HU);
    is_word  = (funct3_i == F3_W);
    f3_legal = is_load_i ? f3_legal_load(funct3_i) : f3_legal_store(funct3_i);
    err      = (is_load_i && is_store_i) || !f3_legal ||
               (is_half && addr_i[0]) || (is_word && (off != 2'b00));
  end

  assign issue = access && !err;

  always_comb begin
    st_mask = MASK_W;
    st_data = store_data_i;
    case (funct3_i)
      F3_B: begin
        st_mask = MASK_B << off;
        st_data = {4{store_data_i[7:0]}};
      end
      F3_H: begin
        st_mask = MASK_H << off;
        st_data = {2{store_data_i[15:0]}};
      end
      default: begin
        st_mask = MASK_W;
        st_data = store_data_i;
      end
    endcase
  end

  // Reset overrides the request so nothing reaches memory while rst is high.
  always_comb begin
    mem.mem_request = issue && !rst;
    mem.mem_we_re   = is_store_i;
    mem.mem_address = addr_i[MEM_AW+1:2];
    mem.mem_data_in = is_store_i ? st_data : 32'h0;
    mem.mem_mask    = is_store_i ? st_mask : MASK_W;
  end

  load_align u_align (
    .word_i   (mem.mem_data_out),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
      load_valid_q <= 1'b0;
      load_data_q  <= 32'h0;
      load_rd_q    <= 5'd0;
      misalign_q   <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      misalign_q   <= access && err;
      case (state_q)
        IDLE: begin
          // Stores finish at the accepting edge; only loads leave IDLE.
          if (issue && is_load_i) begin
            f3_q    <= funct3_i;
            off_q   <= off;
            rd_q    <= rd_in_i;
            state_q <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          load_data_q  <= aligned;
          load_rd_q    <= rd_q;
          load_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_valid_o   = load_valid_q;
  assign load_data_o    = load_data_q;
  assign load_rd_o      = load_rd_q;
  assign misalign_err_o = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory plus a scoreboard of
// expected load results, exercised by one task per scenario.
module tb_load_store_unit;

  localparam int MEM_AW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        load_valid;
  logic [31:0] load_data;
  logic [4:0]  load_rd;
  logic        misalign_err;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem_arr [0:(1<<MEM_AW)-1];

  load_store_unit_if #(.MEM_AW(MEM_AW)) mem_if ();

  load_store_unit #(.MEM_AW(MEM_AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .is_load_i      (is_load),
    .is_store_i     (is_store),
    .funct3_i       (funct3),
    .addr_i         (addr),
    .store_data_i   (store_data),
    .rd_in_i        (rd_in),
    .load_valid_o   (load_valid),
    .load_data_o    (load_data),
    .load_rd_o      (load_rd),
    .misalign_err_o (misalign_err),
    .mem            (mem_if)
  );

  always #5 clk = ~clk;

  // Memory with one-cycle registered read and per-lane byte writes.
  initial begin
    for (int i = 0; i < (1 << MEM_AW); i++) mem_arr[i] = 32'h0;
    mem_if.mem_data_out = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_if.mem_request) begin
      if (mem_if.mem_we_re) begin
        for (int b = 0; b < 4; b++)
          if (mem_if.mem_mask[b])
            mem_arr[mem_if.mem_address][8*b +: 8] <= mem_if.mem_data_in[8*b +: 8];
      end else begin
        mem_if.mem_data_out <= mem_arr[mem_if.mem_address];
      end
    end
  end

  task automatic drive(input logic v, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd);
    req_valid  = v;
    is_load    = ld;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = d;
    rd_in      = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
  endtask

  // Advance one clock and retire any returned load against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (load_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: load_valid with rd=%0d data=%h, none expected", load_rd, load_data);
      end else begin
        e = exp_q.pop_front();
        if (load_data !== e.data || load_rd !== e.rd) begin
          tests_failed++;
          $display("FAIL sb_load: got rd=%0d data=%h, expected rd=%0d data=%h",
                   load_rd, load_data, e.rd, e.data);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h12345678, 5'd0);
    #1;
    tests_run++;
    if (mem_if.mem_request !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mem_request: got %b expected 0", mem_if.mem_request);
    end
    tick();
    tick();
    idle();
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || load_valid !== 1'b0 || misalign_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ready=%b lv=%b mis=%b expected 1 0 0", req_ready, load_valid, misalign_err);
    end
    tests_run++;
    if (load_data !== 32'h0 || load_rd !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_data: data=%h rd=%0d expected 0 0", load_data, load_rd);
    end
  endtask

  // Issue one load, check its request, and check load_valid two cycles later.
  task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd, input logic [31:0] expd);
    drive(1'b1, 1'b1, 1'b0, f3, a, 32'h0, rd);
    #1;
    tests_run++;
    if (mem_if.mem_request !== 1'b1 || mem_if.mem_we_re !== 1'b0 || mem_if.mem_mask !== 4'b1111 ||
        mem_if.mem_address !== a[MEM_AW+1:2]) begin
      tests_failed++;
      $display("FAIL %s_issue: req=%b we=%b mask=%b addr=%h expected 1 0 1111 %h", nm,
               mem_if.mem_request, mem_if.mem_we_re, mem_if.mem_mask, mem_if.mem_address, a[MEM_AW+1:2]);
    end
    exp_q.push_back('{rd: rd, data: expd});
    tick();
    idle();
    #1;
    tests_run++;
    if (req_ready !== 1'b0 || load_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_wait: ready=%b lv=%b expected 0 0", nm, req_ready, load_valid);
    end
    tick();
    tests_run++;
    if (load_valid !== 1'b1 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_latency: lv=%b ready=%b expected 1 1", nm, load_valid, req_ready);
    end
    tick();
  endtask

  task automatic test_store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] emask, input logic [31:0] edata);
    drive(1'b1, 1'b0, 1'b1, f3, a, d, 5'd0);
    #1;
    tests_run++;
    if (mem_if.mem_request !== 1'b1 || mem_if.mem_we_re !== 1'b1 || mem_if.mem_mask !== emask ||
        mem_if.mem_data_in !== edata || mem_if.mem_address !== a[MEM_AW+1:2]) begin
      tests_failed++;
      $display("FAIL %s: req=%b we=%b mask=%b din=%h addr=%h expected 1 1 %b %h %h", nm,
               mem_if.mem_request, mem_if.mem_we_re, mem_if.mem_mask, mem_if.mem_data_in,
               mem_if.mem_address, emask, edata, a[MEM_AW+1:2]);
    end
    tick();
    idle();
  endtask

  task automatic test_word();
    test_store("sw_10", 3'b010, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    test_load("lw_10", 3'b010, 32'h10, 5'd1, 32'hDEADBEEF);
  endtask

  task automatic test_byte();
    test_store("sb_13", 3'b000, 32'h13, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    test_load("lb_13", 3'b000, 32'h13, 5'd2, 32'hFFFFFFA5);
    test_load("lbu_13", 3'b100, 32'h13, 5'd3, 32'h000000A5);
    test_load("lw_10b", 3'b010, 32'h10, 5'd4, 32'hA5ADBEEF);
  endtask

  task automatic test_half();
    test_store("sh_22", 3'b001, 32'h22, 32'h00008001, 4'b1100, 32'h80018001);
    test_load("lh_22", 3'b001, 32'h22, 5'd5, 32'hFFFF8001);
    test_load("lhu_22", 3'b101, 32'h22, 5'd6, 32'h00008001);
    // Upper address bits alias: 0x1022 maps to the same word as 0x22.
    test_load("lhu_alias", 3'b101, 32'h1022, 5'd7, 32'h00008001);
  endtask

  task automatic test_errors();
    logic [31:0] e_addr [5] = '{32'h11, 32'h23, 32'h20, 32'h12, 32'h20};
    logic [2:0]  e_f3   [5] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100};
    logic        e_ld   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        e_st   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, e_ld[i], e_st[i], e_f3[i], e_addr[i], 32'hFFFF_FFFF, 5'd9);
      #1;
      tests_run++;
      if (mem_if.mem_request !== 1'b0 || req_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL err%0d_issue: req=%b ready=%b expected 0 1", i, mem_if.mem_request, req_ready);
      end
      tick();
      idle();
      tests_run++;
      if (misalign_err !== 1'b1 || req_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL err%0d_pulse: mis=%b ready=%b expected 1 1", i, misalign_err, req_ready);
      end
      tick();
      tests_run++;
      if (misalign_err !== 1'b0 || load_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL err%0d_clear: mis=%b lv=%b expected 0 0", i, misalign_err, load_valid);
      end
    end
    // req_valid without either access flag is ignored entirely.
    drive(1'b1, 1'b0, 1'b0, 3'b011, 32'h11, 32'h0, 5'd0);
    #1;
    tick();
    idle();
    tests_run++;
    if (misalign_err !== 1'b0 || mem_if.mem_request !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL noflag_ignored: mis=%b req=%b ready=%b expected 0 0 1", misalign_err, mem_if.mem_request, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h11111111, 5'd0);
    #1;
    tests_run++;
    if (mem_if.mem_request !== 1'b1 || mem_if.mem_address !== 8'h10) begin
      tests_failed++;
      $display("FAIL b2b_sw1: req=%b addr=%h expected 1 10", mem_if.mem_request, mem_if.mem_address);
    end
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h44, 32'h22222222, 5'd0);
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || mem_if.mem_request !== 1'b1 || mem_if.mem_address !== 8'h11) begin
      tests_failed++;
      $display("FAIL b2b_sw2: ready=%b req=%b addr=%h expected 1 1 11", req_ready, mem_if.mem_request, mem_if.mem_address);
    end
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd10);
    #1;
    tests_run++;
    if (mem_if.mem_request !== 1'b1 || mem_if.mem_we_re !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_lw1: req=%b we=%b expected 1 0", mem_if.mem_request, mem_if.mem_we_re);
    end
    exp_q.push_back('{rd: 5'd10, data: 32'h11111111});
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 5'd11);
    #1;
    tests_run++;
    if (req_ready !== 1'b0 || mem_if.mem_request !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_stall: ready=%b req=%b expected 0 0", req_ready, mem_if.mem_request);
    end
    tick();
    tests_run++;
    if (load_valid !== 1'b1 || req_ready !== 1'b1 || mem_if.mem_request !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_lw2_issue: lv=%b ready=%b req=%b expected 1 1 1", load_valid, req_ready, mem_if.mem_request);
    end
    exp_q.push_back('{rd: 5'd11, data: 32'h22222222});
    tick();
    idle();
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_lw2_stall: ready=%b expected 0", req_ready);
    end
    tick();
    tests_run++;
    if (load_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_lw2_ret: lv=%b expected 1", load_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd12);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (load_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_wait: lv=%b ready=%b expected 0 1", load_valid, req_ready);
    end
    tick();
    tests_run++;
    if (load_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_after: lv=%b ready=%b expected 0 1", load_valid, req_ready);
    end
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid_load();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: %0d loads outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
